// File: rtl/seg_scan_decoder_if.sv
// rtl/seg_scan_decoder_if.sv - scan-line inputs and decoded frame outputs of seg_scan_decoder
// master drives the multiplexed display lines; slave is the decoder.
interface seg_scan_decoder_if;
  logic [7:0]  seg1;
  logic [7:0]  seg2;
  logic [7:0]  an;
  logic [31:0] digits;
  logic [7:0]  dp;
  logic [7:0]  blank;
  logic        frame_valid;
  logic        glyph_err;
  logic        stale;

  modport master (
    output seg1, seg2, an,
    input  digits, dp, blank, frame_valid, glyph_err, stale
  );

  modport slave (
    input  seg1, seg2, an,
    output digits, dp, blank, frame_valid, glyph_err, stale
  );
endinterface

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - decodes a scanned 8-digit seven-segment display back into digit codes
// Each scan slot is captured after it has held steady; a full set of four slots is published at once.
module seg_scan_decoder #(
  parameter int STABLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic              clk,
  input  logic              rst,
  seg_scan_decoder_if.slave bus
);

  localparam int CW = $clog2(STABLE_CYC);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYC - 1);
  localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYC - 2);
  localparam logic [TW-1:0] T_MAX   = TW'(TIMEOUT_CYC);

  // Result is {err, blank, code}.
  function automatic logic [5:0] decode7(input logic [6:0] p);
    logic [5:0] r;
    r = 6'b10_1111;
    case (p)
      7'h7E: r = 6'h00;
      7'h30: r = 6'h01;
      7'h6D: r = 6'h02;
      7'h79: r = 6'h03;
      7'h33: r = 6'h04;
      7'h5B: r = 6'h05;
      7'h5F: r = 6'h06;
      7'h70: r = 6'h07;
      7'h7F: r = 6'h08;
      7'h7B: r = 6'h09;
      7'h77: r = 6'h0A;
      7'h1F: r = 6'h0B;
      7'h4E: r = 6'h0C;
      7'h3D: r = 6'h0D;
      7'h4F: r = 6'h0E;
      7'h47: r = 6'h0F;
      7'h00: r = 6'b01_1111;
      default: r = 6'b10_1111;
    endcase
    return r;
  endfunction

  logic [7:0]    s_seg1, s_seg2, s_an;
  logic [23:0]   prev;
  logic [CW-1:0] cnt;
  logic [TW-1:0] tcnt;
  logic [3:0]    mask;
  logic [31:0]   sh_digits, out_digits;
  logic [7:0]    sh_dp, sh_blank, out_dp, out_blank;
  logic          out_fv, out_gerr;

  logic          s_legal, same, capture;
  logic [1:0]    s_idx;
  logic [5:0]    dec_lo, dec_hi;
  logic [2:0]    pos_lo, pos_hi;
  logic [3:0]    cap_bit;

  // Legal only when both halves select the same single position.
  always_comb begin
    s_legal = 1'b0;
    s_idx   = 2'd0;
    if (s_an[7:4] == s_an[3:0]) begin
      case (s_an[3:0])
        4'b0001: begin s_legal = 1'b1; s_idx = 2'd0; end
        4'b0010: begin s_legal = 1'b1; s_idx = 2'd1; end
        4'b0100: begin s_legal = 1'b1; s_idx = 2'd2; end
        4'b1000: begin s_legal = 1'b1; s_idx = 2'd3; end
        default: begin s_legal = 1'b0; s_idx = 2'd0; end
      endcase
    end
  end

  assign same    = ({s_seg1, s_seg2, s_an} == prev);
  assign capture = s_legal && same && (cnt == CNT_PRE);
  assign dec_lo  = decode7(s_seg1[7:1]);
  assign dec_hi  = decode7(s_seg2[7:1]);
  assign pos_lo  = {1'b0, s_idx};
  assign pos_hi  = {1'b1, s_idx};
  assign cap_bit = 4'b0001 << s_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_seg1 <= 8'h00;
      s_seg2 <= 8'h00;
      s_an   <= 8'h00;
      prev   <= 24'h0;
      cnt    <= '0;
    end else begin
      s_seg1 <= bus.seg1;
      s_seg2 <= bus.seg2;
      s_an   <= bus.an;
      prev   <= {s_seg1, s_seg2, s_an};
      if (!s_legal || !same)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_digits <= 32'hFFFF_FFFF;
      sh_dp     <= 8'h00;
      sh_blank  <= 8'hFF;
      out_gerr  <= 1'b0;
    end else if (capture) begin
      sh_digits[{pos_lo, 2'b00} +: 4] <= dec_lo[3:0];
      sh_digits[{pos_hi, 2'b00} +: 4] <= dec_hi[3:0];
      sh_blank[pos_lo]                <= dec_lo[4];
      sh_blank[pos_hi]                <= dec_hi[4];
      sh_dp[pos_lo]                   <= s_seg1[0];
      sh_dp[pos_hi]                   <= s_seg2[0];
      if (dec_lo[5] || dec_hi[5])
        out_gerr <= 1'b1;
    end
  end

  // The mask completes on a capture edge; the shadow is published one edge later.
  always_ff @(posedge clk) begin
    if (rst) begin
      mask       <= 4'h0;
      out_digits <= 32'hFFFF_FFFF;
      out_dp     <= 8'h00;
      out_blank  <= 8'hFF;
      out_fv     <= 1'b0;
    end else if (mask == 4'hF) begin
      mask       <= capture ? cap_bit : 4'h0;
      out_digits <= sh_digits;
      out_dp     <= sh_dp;
      out_blank  <= sh_blank;
      out_fv     <= 1'b1;
    end else begin
      mask   <= capture ? (mask | cap_bit) : mask;
      out_fv <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      tcnt <= '0;
    else if (capture)
      tcnt <= '0;
    else if (tcnt != T_MAX)
      tcnt <= tcnt + TW'(1);
  end

  assign bus.digits      = out_digits;
  assign bus.dp          = out_dp;
  assign bus.blank       = out_blank;
  assign bus.frame_valid = out_fv;
  assign bus.glyph_err   = out_gerr;
  assign bus.stale       = (tcnt == T_MAX);

endmodule
